// File: rtl/ysyx_22041752_io_bridge_pkg.sv
// Shared definitions for the uncached MMIO bridge: default widths and bus FSM encodings.
package ysyx_22041752_io_bridge_pkg;
  localparam int IO_ADDR_WD     = 32;
  localparam int IO_DATA_WD     = 64;
  localparam int IO_WBUF_DEPTH  = 4;
  localparam int IO_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    IO_IDLE  = 3'd0,
    IO_WREQ  = 3'd1,
    IO_WRESP = 3'd2,
    IO_RREQ  = 3'd3,
    IO_RRESP = 3'd4
  } io_state_e;
endpackage

// File: rtl/ysyx_22041752_io_wbuf.sv
// Posted-write FIFO of {addr, wen, wdata}; extra pointer MSB separates full from empty.
module ysyx_22041752_io_wbuf #(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int WW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_addr,
  input  logic [WW-1:0] i_wen,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW-1:0] o_head_addr,
  output logic [WW-1:0] o_head_wen,
  output logic [DW-1:0] o_head_wdata
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int EW = AW + WW + DW;

  logic [PW-1:0] r_wptr, r_rptr;
  logic [EW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // A push into a full buffer alongside a pop lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[IW-1:0]] <= {i_addr, i_wen, i_wdata};
  end

  assign o_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[IW-1:0] == r_rptr[IW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign {o_head_addr, o_head_wen, o_head_wdata} = r_mem[r_rptr[IW-1:0]];
endmodule

// File: rtl/ysyx_22041752_io_bridge.sv
// Uncached MMIO bridge: posted writes via a write buffer, blocking reads behind a drained buffer.
// Optional bus watchdog enabled by defining YSYX_22041752_IO_TIMEOUT_EN.
module ysyx_22041752_io_bridge
  import ysyx_22041752_io_bridge_pkg::*;
#(
  parameter int ADDR_WD     = IO_ADDR_WD,
  parameter int DATA_WD     = IO_DATA_WD,
  parameter int WEN_WD      = DATA_WD / 8,
  parameter int WBUF_DEPTH  = IO_WBUF_DEPTH,
  parameter int TIMEOUT_CYC = IO_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               io_en,
  input  logic [WEN_WD-1:0]  io_wen,
  input  logic [ADDR_WD-1:0] io_data_addr,
  input  logic [DATA_WD-1:0] io_data_wdata,
  output logic [DATA_WD-1:0] io_data_rdata,
  output logic               io_miss,
  output logic               io_err,
  output logic               sram_req,
  input  logic               sram_ready,
  output logic [WEN_WD-1:0]  sram_wen,
  output logic [ADDR_WD-1:0] sram_addr,
  output logic [DATA_WD-1:0] sram_wdata,
  input  logic [DATA_WD-1:0] sram_rdata,
  input  logic               sram_valid
);
  io_state_e r_state, w_state_nxt;

  logic               r_hold_vld, r_hold_wr;
  logic [ADDR_WD-1:0] r_hold_addr;
  logic [WEN_WD-1:0]  r_hold_wen;
  logic [DATA_WD-1:0] r_hold_wdata;
  logic [DATA_WD-1:0] r_rdata;

  logic               w_full, w_empty, w_tmo;
  logic [ADDR_WD-1:0] w_head_addr;
  logic [WEN_WD-1:0]  w_head_wen;
  logic [DATA_WD-1:0] w_head_wdata;

  logic w_accept, w_is_wr, w_rd_done, w_rd_tmo, w_pop;
  logic w_push_direct, w_push_hold, w_push;

  assign w_accept      = io_en & ~r_hold_vld;
  assign w_is_wr       = |io_wen;
  assign w_rd_done     = (r_state == IO_RRESP) & sram_valid;
  assign w_rd_tmo      = w_tmo & ((r_state == IO_RREQ) | (r_state == IO_RRESP));
  assign w_pop         = ((r_state == IO_WRESP) & sram_valid)
                       | (w_tmo & ((r_state == IO_WREQ) | (r_state == IO_WRESP)));
  assign w_push_direct = w_accept & w_is_wr & ~w_full;
  assign w_push_hold   = r_hold_vld & r_hold_wr & (~w_full | w_pop);
  assign w_push        = w_push_direct | w_push_hold;

  ysyx_22041752_io_wbuf #(
    .AW(ADDR_WD), .DW(DATA_WD), .WW(WEN_WD), .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_addr       (r_hold_vld ? r_hold_addr  : io_data_addr),
    .i_wen        (r_hold_vld ? r_hold_wen   : io_wen),
    .i_wdata      (r_hold_vld ? r_hold_wdata : io_data_wdata),
    .i_pop        (w_pop),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head_addr  (w_head_addr),
    .o_head_wen   (w_head_wen),
    .o_head_wdata (w_head_wdata)
  );

  // Hold reg doubles as the stall: the core is blocked exactly while it is occupied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_vld   <= 1'b0;
      r_hold_wr    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wen   <= '0;
      r_hold_wdata <= '0;
    end else if (w_accept && (!w_is_wr || w_full)) begin
      r_hold_vld   <= 1'b1;
      r_hold_wr    <= w_is_wr;
      r_hold_addr  <= io_data_addr;
      r_hold_wen   <= io_wen;
      r_hold_wdata <= io_data_wdata;
    end else if (w_push_hold || w_rd_done || w_rd_tmo) begin
      r_hold_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_rdata <= '0;
    else if (w_rd_tmo)  r_rdata <= '1;
    else if (w_rd_done) r_rdata <= sram_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IO_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    sram_req    = 1'b0;
    sram_wen    = '0;
    sram_addr   = '0;
    sram_wdata  = '0;
    case (r_state)
      IO_IDLE: begin
        if (!w_empty)                      w_state_nxt = IO_WREQ;
        else if (r_hold_vld && !r_hold_wr) w_state_nxt = IO_RREQ;
      end
      IO_WREQ: begin
        sram_req   = 1'b1;
        sram_wen   = w_head_wen;
        sram_addr  = w_head_addr;
        sram_wdata = w_head_wdata;
        if (sram_ready) w_state_nxt = IO_WRESP;
      end
      IO_WRESP: if (sram_valid) w_state_nxt = IO_IDLE;
      IO_RREQ: begin
        sram_req  = 1'b1;
        sram_addr = r_hold_addr;
        if (sram_ready) w_state_nxt = IO_RRESP;
      end
      IO_RRESP: if (sram_valid) w_state_nxt = IO_IDLE;
      default:  w_state_nxt = IO_IDLE;
    endcase
    if (w_tmo) w_state_nxt = IO_IDLE;
  end

`ifdef YSYX_22041752_IO_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC) + 1;
  logic [WDW-1:0] r_wdog;
  logic           r_err;

  // Counts cycles spent in the current busy state; any transition restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (r_state == IO_IDLE || w_state_nxt != r_state) r_wdog <= '0;
      else                                              r_wdog <= r_wdog + WDW'(1);
    end
  end

  assign w_tmo  = (r_state != IO_IDLE) && (r_wdog == WDW'(TIMEOUT_CYC - 1));
  assign io_err = r_err;
`else
  assign w_tmo  = 1'b0;
  assign io_err = 1'b0;
`endif

  assign io_miss       = r_hold_vld;
  assign io_data_rdata = r_rdata;
endmodule
